// File: rtl/gsim_pkg.sv
// gsim_pkg
// Shared constants and types for the GSIM residual checker.
//   N          : default vector length (rows)
//   B_W/X_W/R_W: widths of b (integer), x (16.16) and r (16.16, widened)
//   FRAC_W     : fractional bits of the fixed-point format
//   COEF_*     : band coefficients of M by distance from the diagonal
//   state_t    : residual FSM states
package gsim_pkg;

    localparam int N      = 16;
    localparam int B_W    = 16;
    localparam int X_W    = 32;
    localparam int R_W    = 40;
    localparam int C_W    = 6;
    localparam int FRAC_W = 16;
    localparam int TAPS   = 7;

    localparam logic signed [C_W-1:0] COEF_D0 = 6'sd20;
    localparam logic signed [C_W-1:0] COEF_D1 = -6'sd13;
    localparam logic signed [C_W-1:0] COEF_D2 = 6'sd6;
    localparam logic signed [C_W-1:0] COEF_D3 = -6'sd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2
    } state_t;

    // Coefficient of M at distance d from the diagonal.
    function automatic logic signed [C_W-1:0] band_coef(input logic [1:0] d);
        logic signed [C_W-1:0] c;
        case (d)
            2'd0:    c = COEF_D0;
            2'd1:    c = COEF_D1;
            2'd2:    c = COEF_D2;
            2'd3:    c = COEF_D3;
            default: c = 6'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gsim_band_mac.sv
// gsim_band_mac
// Combinational 7-tap signed multiply-accumulate for one row of M*x - b.
//   i_taps : x[i-3..i+3] as index 0..6 (out-of-range entries already zeroed)
//   i_b    : b[i], signed integer
//   o_r    : (M*x)[i] - (b[i] << 16), exact, signed 16.16 in R_W bits
module gsim_band_mac
    import gsim_pkg::*;
(
    input  logic [TAPS-1:0][X_W-1:0] i_taps,
    input  logic [B_W-1:0]           i_b,
    output logic [R_W-1:0]           o_r
);

    logic signed [R_W-1:0] w_acc;
    logic        [R_W-1:0] w_x_ext;
    logic        [R_W-1:0] w_c_ext;
    logic        [R_W-1:0] w_b_ext;
    logic signed [C_W-1:0] w_coef;
    logic        [1:0]     w_dist;

    // Sum of sign-extended products; R_W bits hold the worst case (60 * 2^31) exactly.
    always_comb begin
        w_acc   = '0;
        w_dist  = 2'd0;
        w_coef  = 6'sd0;
        w_x_ext = '0;
        w_c_ext = '0;
        for (int t = 0; t < TAPS; t++) begin
            if (t < 3) begin
                w_dist = 2'(3 - t);
            end else begin
                w_dist = 2'(t - 3);
            end
            w_coef  = band_coef(w_dist);
            w_x_ext = {{(R_W-X_W){i_taps[t][X_W-1]}}, i_taps[t]};
            w_c_ext = {{(R_W-C_W){w_coef[C_W-1]}}, w_coef};
            w_acc   = w_acc + ($signed(w_x_ext) * $signed(w_c_ext));
        end
        // b is an integer: align it with the 16.16 products.
        w_b_ext = {{(R_W-B_W-FRAC_W){i_b[B_W-1]}}, i_b, 16'd0};
        o_r     = w_acc - w_b_ext;
    end

endmodule

// File: rtl/gsim_residual.sv
// gsim_residual
// Monitors the b stream into a GSIM solver and the x stream out of it, then
// emits the residual r = M*x - b one row per cycle and flags whether every
// row is within TOL.
//   clk, reset       : clock; asynchronous active-high reset
//   in_en, b_in      : b element strobe / value (signed integer)
//   x_valid, x_in    : x element strobe / value (signed 16.16)
//   r_valid, r_out   : residual row strobe / value (signed 16.16, 40 bits)
//   done             : pulse with the last row
//   pass             : all rows of the last completed run within TOL
// N is assumed to be at least 4 so the buffer index has at least 2 bits.
module gsim_residual #(
    parameter int                         N   = gsim_pkg::N,
    parameter logic [gsim_pkg::R_W-1:0]   TOL = 40'd66
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_en,
    input  logic [gsim_pkg::B_W-1:0]      b_in,
    input  logic                          x_valid,
    input  logic [gsim_pkg::X_W-1:0]      x_in,
    output logic                          r_valid,
    output logic [gsim_pkg::R_W-1:0]      r_out,
    output logic                          done,
    output logic                          pass
);

    import gsim_pkg::*;

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    state_t               r_state;
    state_t               w_next_state;
    logic [CW-1:0]        r_b_cnt;
    logic [CW-1:0]        r_x_cnt;
    logic [CW-1:0]        r_row;
    logic                 r_all_ok;
    logic [B_W-1:0]       r_b_buf [N];
    logic [X_W-1:0]       r_x_buf [N];

    logic                 w_cap_ok;
    logic                 w_b_cap;
    logic                 w_x_cap;
    logic                 w_full;
    logic                 w_entry;
    logic                 w_emit;
    logic                 w_last;
    logic                 w_finish;
    logic                 w_ok;
    logic [CW-1:0]        w_row_sel;
    logic [B_W-1:0]       w_b_sel;
    logic [TAPS-1:0][X_W-1:0] w_taps;
    logic [R_W-1:0]       w_mac;
    int                   w_tap_idx;

    // Capture qualifiers: IDLE accepts the first element that starts a run.
    always_comb begin
        w_cap_ok = (r_state == ST_IDLE) || (r_state == ST_LOAD);
        w_b_cap  = w_cap_ok && in_en   && (r_b_cnt != CW'(N));
        w_x_cap  = w_cap_ok && x_valid && (r_x_cnt != CW'(N));
        w_full   = (r_b_cnt == CW'(N)) && (r_x_cnt == CW'(N));
    end

    // Row 0 is computed in the LOAD cycle that sees both buffers full, so the
    // registered result appears in the first COMPUTE cycle; r_row then holds
    // the next row to compute and reaches N while the last row is displayed.
    always_comb begin
        w_entry  = (r_state == ST_LOAD) && w_full;
        w_finish = (r_state == ST_COMPUTE) && (r_row == CW'(N));
        if (r_state == ST_COMPUTE) begin
            w_row_sel = r_row;
        end else begin
            w_row_sel = '0;
        end
        w_emit = w_entry || ((r_state == ST_COMPUTE) && (r_row != CW'(N)));
        w_last = w_emit && (w_row_sel == CW'(N - 1));
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_en || x_valid) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_full) begin
                    w_next_state = ST_COMPUTE;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (w_finish) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_COMPUTE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Gather x[i-3..i+3]; indices outside 0..N-1 read as zero (no wrap).
    always_comb begin
        w_taps    = '0;
        w_tap_idx = 0;
        for (int t = 0; t < TAPS; t++) begin
            w_tap_idx = int'(w_row_sel) + t - 3;
            if ((w_tap_idx >= 0) && (w_tap_idx < N)) begin
                w_taps[t] = r_x_buf[w_tap_idx[IW-1:0]];
            end else begin
                w_taps[t] = '0;
            end
        end
        if (w_row_sel < CW'(N)) begin
            w_b_sel = r_b_buf[w_row_sel[IW-1:0]];
        end else begin
            w_b_sel = '0;
        end
    end

    gsim_band_mac u_mac (
        .i_taps (w_taps),
        .i_b    (w_b_sel),
        .o_r    (w_mac)
    );

    // Per-row tolerance test on the unregistered MAC result.
    always_comb begin
        w_ok = ($signed(w_mac) <= $signed(TOL)) && ($signed(w_mac) >= -$signed(TOL));
    end

    // Buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_b_cap) begin
            r_b_buf[r_b_cnt[IW-1:0]] <= b_in;
        end
        if (w_x_cap) begin
            r_x_buf[r_x_cnt[IW-1:0]] <= x_in;
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_b_cnt  <= '0;
            r_x_cnt  <= '0;
            r_row    <= '0;
            r_all_ok <= 1'b0;
            r_valid  <= 1'b0;
            r_out    <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_finish) begin
                r_b_cnt <= '0;
                r_x_cnt <= '0;
                r_row   <= '0;
            end else begin
                if (w_b_cap) begin
                    r_b_cnt <= r_b_cnt + 1'b1;
                end
                if (w_x_cap) begin
                    r_x_cnt <= r_x_cnt + 1'b1;
                end
                if (w_emit) begin
                    r_row <= w_row_sel + 1'b1;
                end
            end
            r_valid <= w_emit;
            done    <= w_last;
            if (w_emit) begin
                r_out <= w_mac;
            end else begin
                r_out <= '0;
            end
            if (w_entry) begin
                r_all_ok <= w_ok;
                pass     <= w_last && w_ok;
            end else if (w_emit) begin
                r_all_ok <= r_all_ok && w_ok;
                if (w_last) begin
                    pass <= r_all_ok && w_ok;
                end
            end
        end
    end

endmodule
